// File: rtl/uart_pkt_pkg.sv
// Shared encodings for the UART packet controller: FSM states, command codes, error causes.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_REQ
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_CMD = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // A length byte of zero encodes a full 256-byte transfer.
    function automatic logic [8:0] len_to_cnt(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Purpose: turn each falling edge of rx_busy into a one-cycle byte strobe with the byte captured.
// Latency: byte_vld/byte_dat valid one cycle after the falling edge is seen on the registered copy.
// Backpressure: none; every completed UART byte produces exactly one strobe.
module uart_byte_strobe (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic [7:0] rx_data,
    input  logic       rx_busy,
    output logic       byte_vld,
    output logic [7:0] byte_dat
);

    logic rx_busy_q;
    logic busy_fall;

    assign busy_fall = rx_busy_q && !rx_busy;

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_busy_q <= 1'b0;
            byte_vld  <= 1'b0;
            byte_dat  <= 8'd0;
        end else begin
            rx_busy_q <= rx_busy;
            byte_vld  <= busy_fall;
            if (busy_fall) begin
                byte_dat <= rx_data;
            end
        end
    end

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Purpose: parse HEADER/cmd/len[/payload][/checksum] UART frames into SDRAM write bytes or a read request.
// Latency: wr_valid/rd_req/pkt_* register one cycle after the internal byte strobe; checksum byte only with UART_PKT_CHKSUM_EN.
// Backpressure: wr_valid holds until wr_ready; a new byte while still unaccepted aborts with overrun; rd_req holds until rd_ack.
module uart_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic [7:0] rx_data,
    input  logic       rx_busy,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       rd_req,
    output logic [8:0] rd_len,
    input  logic       rd_ack,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] IDLE_LIM = TW'(TIMEOUT_CYC - 1);

    logic          byte_vld;
    logic [7:0]    byte_dat;

    state_t        state, state_nxt;
    logic          is_wr, is_wr_nxt;
    logic [8:0]    cnt, cnt_nxt;
    logic [7:0]    csum, csum_nxt;
    logic [TW-1:0] idle_cnt, idle_nxt;
    logic          wr_valid_nxt, rd_req_nxt, done_nxt, err_nxt;
    logic [7:0]    wr_data_nxt;
    logic [8:0]    rd_len_nxt;
    logic [1:0]    code_nxt, abort_code;
    logic          timed, overrun, abort;

    uart_byte_strobe u_strobe (
        .SYS_CLK  (SYS_CLK),
        .RST_N    (RST_N),
        .rx_data  (rx_data),
        .rx_busy  (rx_busy),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat)
    );

    // A byte landing while the previous one is still unaccepted would be lost.
    assign overrun = byte_vld && wr_valid && !wr_ready;
    assign timed   = (state == ST_CMD) || (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);

    always_comb begin
        state_nxt    = state;
        is_wr_nxt    = is_wr;
        cnt_nxt      = cnt;
        csum_nxt     = csum;
        idle_nxt     = '0;
        wr_valid_nxt = wr_valid && !wr_ready;
        wr_data_nxt  = wr_data;
        rd_req_nxt   = rd_req;
        rd_len_nxt   = rd_len;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        code_nxt     = err_code;
        abort        = 1'b0;
        abort_code   = ERR_NONE;

        if (timed && !byte_vld) begin
            idle_nxt = idle_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (byte_vld && byte_dat == HEADER) begin
                    state_nxt = ST_CMD;
                    csum_nxt  = 8'd0;
                end
            end
            ST_CMD: begin
                if (byte_vld) begin
                    if (byte_dat == CMD_WR || byte_dat == CMD_RD) begin
                        is_wr_nxt = (byte_dat == CMD_WR);
                        csum_nxt  = byte_dat;
                        state_nxt = ST_LEN;
                    end else begin
                        abort      = 1'b1;
                        abort_code = ERR_BAD_CMD;
                    end
                end
            end
            ST_LEN: begin
                if (byte_vld) begin
                    cnt_nxt  = len_to_cnt(byte_dat);
                    csum_nxt = csum + byte_dat;
                    if (is_wr) begin
                        state_nxt = ST_DATA;
                    end else begin
                        rd_len_nxt = len_to_cnt(byte_dat);
`ifdef UART_PKT_CHKSUM_EN
                        state_nxt  = ST_CHK;
`else
                        state_nxt  = ST_REQ;
                        rd_req_nxt = 1'b1;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (overrun) begin
                    abort      = 1'b1;
                    abort_code = ERR_OVERRUN;
                end else if (byte_vld) begin
                    wr_valid_nxt = 1'b1;
                    wr_data_nxt  = byte_dat;
                    csum_nxt     = csum + byte_dat;
                    cnt_nxt      = cnt - 9'd1;
                    if (cnt == 9'd1) begin
`ifdef UART_PKT_CHKSUM_EN
                        state_nxt = ST_CHK;
`else
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
`endif
                    end
                end
            end
            ST_CHK: begin
                if (overrun) begin
                    abort      = 1'b1;
                    abort_code = ERR_OVERRUN;
                end else if (byte_vld) begin
                    if (byte_dat != csum) begin
                        abort      = 1'b1;
                        abort_code = ERR_TIMEOUT;
                    end else if (is_wr) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt  = ST_REQ;
                        rd_req_nxt = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    rd_req_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (timed && !byte_vld && idle_cnt == IDLE_LIM) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end

        if (abort) begin
            state_nxt    = ST_IDLE;
            err_nxt      = 1'b1;
            code_nxt     = abort_code;
            wr_valid_nxt = 1'b0;
            rd_req_nxt   = 1'b0;
            idle_nxt     = '0;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            is_wr    <= 1'b0;
            cnt      <= 9'd0;
            csum     <= 8'd0;
            idle_cnt <= '0;
            wr_valid <= 1'b0;
            wr_data  <= 8'd0;
            rd_req   <= 1'b0;
            rd_len   <= 9'd0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            is_wr    <= is_wr_nxt;
            cnt      <= cnt_nxt;
            csum     <= csum_nxt;
            idle_cnt <= idle_nxt;
            wr_valid <= wr_valid_nxt;
            wr_data  <= wr_data_nxt;
            rd_req   <= rd_req_nxt;
            rd_len   <= rd_len_nxt;
            pkt_done <= done_nxt;
            pkt_err  <= err_nxt;
            err_code <= code_nxt;
        end
    end

endmodule
